// File: rtl/cdb_arbiter_if.sv
// Bundle of the two producer handshakes (ALU, LSB) and the registered CDB broadcast.
// The slave modport is the arbiter; the master modport is whatever drives the producers.
interface cdb_arbiter_if;
   logic        alu_valid;
   logic        alu_ready;
   logic [31:0] alu_res;
   logic [4:0]  alu_rob_id;
   logic        alu_jump_choice;
   logic [31:0] alu_pc;

   logic        lsb_valid;
   logic        lsb_ready;
   logic [31:0] lsb_res;
   logic [4:0]  lsb_rob_id;

   logic        cdb_valid;
   logic [31:0] cdb_res;
   logic [4:0]  cdb_rob_id;
   logic        cdb_jump_choice;
   logic [31:0] cdb_pc;
   logic        cdb_src;

   modport slave (
      input  alu_valid, alu_res, alu_rob_id, alu_jump_choice, alu_pc,
      input  lsb_valid, lsb_res, lsb_rob_id,
      output alu_ready, lsb_ready,
      output cdb_valid, cdb_res, cdb_rob_id, cdb_jump_choice, cdb_pc, cdb_src
   );

   modport master (
      output alu_valid, alu_res, alu_rob_id, alu_jump_choice, alu_pc,
      output lsb_valid, lsb_res, lsb_rob_id,
      input  alu_ready, lsb_ready,
      input  cdb_valid, cdb_res, cdb_rob_id, cdb_jump_choice, cdb_pc, cdb_src
   );
endinterface

// File: rtl/cdb_arbiter.sv
// Common data bus arbiter: one FIFO per producer (ALU, LSB), one registered broadcast per cycle.
// Define CDB_LSB_PRIORITY_EN for fixed LSB priority; default is round-robin.
module cdb_arbiter #(
   parameter int DEPTH = 4
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         rdy,
   input  logic         flush,
   cdb_arbiter_if.slave bus
);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;
   localparam logic [CW-1:0] FULL = CW'(DEPTH);

   typedef struct packed {
      logic [31:0] res;
      logic [4:0]  rob_id;
      logic        jump_choice;
      logic [31:0] pc;
   } entry_t;

   entry_t          alu_mem [DEPTH];
   entry_t          lsb_mem [DEPTH];
   logic [AW-1:0]   alu_rd, alu_wr, lsb_rd, lsb_wr;
   logic [CW-1:0]   alu_cnt, lsb_cnt;
`ifndef CDB_LSB_PRIORITY_EN
   logic            last_grant;  // 1 = LSB won the last grant
`endif

   logic   alu_push, lsb_push, alu_pop, lsb_pop;
   logic   alu_ne, lsb_ne, any_grant, grant_lsb;
   entry_t head;

   // Handshake: a producer's entry is taken at the edge where valid && ready;
   // ready depends only on registered count (no credit for a same-edge pop),
   // so a refused entry is simply dropped and the producer must present it again.
   assign bus.alu_ready = rdy && !flush && (alu_cnt < FULL);
   assign bus.lsb_ready = rdy && !flush && (lsb_cnt < FULL);

   always_comb begin
      alu_push  = bus.alu_valid && bus.alu_ready;
      lsb_push  = bus.lsb_valid && bus.lsb_ready;
      alu_ne    = (alu_cnt != '0);
      lsb_ne    = (lsb_cnt != '0);
      any_grant = alu_ne || lsb_ne;
`ifdef CDB_LSB_PRIORITY_EN
      grant_lsb = lsb_ne;
`else
      grant_lsb = lsb_ne && (!alu_ne || !last_grant);
`endif
      alu_pop   = any_grant && !grant_lsb;
      lsb_pop   = grant_lsb;
      head      = grant_lsb ? lsb_mem[lsb_rd] : alu_mem[alu_rd];
   end

   // Storage has no reset; occupancy is tracked entirely by pointers and counts.
   always_ff @(posedge clk) begin
      if (!rst && alu_push) begin
         alu_mem[alu_wr] <= '{res: bus.alu_res, rob_id: bus.alu_rob_id,
                              jump_choice: bus.alu_jump_choice, pc: bus.alu_pc};
      end
      if (!rst && lsb_push) begin
         lsb_mem[lsb_wr] <= '{res: bus.lsb_res, rob_id: bus.lsb_rob_id,
                              jump_choice: 1'b0, pc: 32'h0};
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         alu_rd              <= '0;
         alu_wr              <= '0;
         alu_cnt             <= '0;
         lsb_rd              <= '0;
         lsb_wr              <= '0;
         lsb_cnt             <= '0;
`ifndef CDB_LSB_PRIORITY_EN
         last_grant          <= 1'b1;
`endif
         bus.cdb_valid       <= 1'b0;
         bus.cdb_res         <= '0;
         bus.cdb_rob_id      <= '0;
         bus.cdb_jump_choice <= 1'b0;
         bus.cdb_pc          <= '0;
         bus.cdb_src         <= 1'b0;
      end else if (flush) begin
         alu_rd        <= '0;
         alu_wr        <= '0;
         alu_cnt       <= '0;
         lsb_rd        <= '0;
         lsb_wr        <= '0;
         lsb_cnt       <= '0;
         bus.cdb_valid <= 1'b0;
      end else if (rdy) begin
         if (alu_push) alu_wr <= alu_wr + 1'b1;
         if (lsb_push) lsb_wr <= lsb_wr + 1'b1;
         if (alu_pop)  alu_rd <= alu_rd + 1'b1;
         if (lsb_pop)  lsb_rd <= lsb_rd + 1'b1;
         alu_cnt <= alu_cnt + CW'(alu_push) - CW'(alu_pop);
         lsb_cnt <= lsb_cnt + CW'(lsb_push) - CW'(lsb_pop);
         bus.cdb_valid <= any_grant;
         if (any_grant) begin
            bus.cdb_res         <= head.res;
            bus.cdb_rob_id      <= head.rob_id;
            bus.cdb_jump_choice <= head.jump_choice;
            bus.cdb_pc          <= head.pc;
            bus.cdb_src         <= grant_lsb;
`ifndef CDB_LSB_PRIORITY_EN
            last_grant          <= grant_lsb;
`endif
         end
      end
   end
endmodule

// File: doc/cdb_arbiter.md
CDB_ARBITER -- requirements
Module: cdb_arbiter

Interface
REQ-001 The block SHALL expose parameter: DEPTH, 4, entries per source FIFO (power of two, >=2).
REQ-002 The block SHALL have ports: clk  in  1  clock; rst  in  1  reset, synchronous, active-high.
REQ-003 The block SHALL have ports: rdy  in  1  global enable; flush  in  1  misprediction flush, the ROB wrong_commit.
REQ-004 The block SHALL have ALU-side ports: alu_valid in 1; alu_ready out 1; alu_res in 32; alu_rob_id in 5; alu_jump_choice in 1; alu_pc in 32.
REQ-005 The block SHALL have LSB-side ports: lsb_valid in 1; lsb_ready out 1; lsb_res in 32; lsb_rob_id in 5.
REQ-006 The block SHALL have CDB ports, all registered: cdb_valid out 1; cdb_res out 32; cdb_rob_id out 5; cdb_jump_choice out 1; cdb_pc out 32; cdb_src out 1 (0=ALU, 1=LSB).

Function
REQ-007 The block SHALL hold one circular FIFO of DEPTH entries per source, with entry format {res, rob_id, jump_choice, pc}.
- LSB entries store jump_choice=0 and pc=0.
REQ-008 Each FIFO SHALL keep a read pointer, a write pointer and a count of width log2(DEPTH)+1.
- Pointers wrap from DEPTH-1 to 0.
REQ-009 The x_ready output SHALL equal rdy && !flush && (count_x < DEPTH).
- No same-cycle pop credit: a full FIFO deasserts ready even while it is being popped.
REQ-010 A push SHALL occur at the clock edge where x_valid && x_ready; otherwise the input is ignored and is not held.
REQ-011 At each edge with rdy high and no flush, the arbiter SHALL select one non-empty FIFO head, pop it and load it into the cdb_* registers with cdb_valid=1.
- If both FIFOs are empty, cdb_valid SHALL be 0.
REQ-012 Arbitration SHALL be round-robin using a 1-bit last_grant register.
- Both FIFOs non-empty: grant the source opposite last_grant.
- Exactly one non-empty: grant that source.
- last_grant updates only on a grant.
REQ-013 The arbiter SHALL consider only entries present before the edge, so latency is fixed.
- An entry pushed at edge N is broadcast no earlier than edge N+1.
- Such an entry is visible on the CDB during the cycle after edge N+1.
REQ-014 A simultaneous push and pop on the same FIFO SHALL leave count unchanged and SHALL be legal at any fill level below DEPTH.
REQ-015 flush SHALL act regardless of rdy.
- At the edge it is sampled: both FIFOs empty, pointers and counts 0, cdb_valid 0, pushes on that edge discarded.
- last_grant is unchanged.
REQ-016 With rdy low and no flush/rst, all registers SHALL hold, including cdb_valid and the cdb_* payload, and no push or pop SHALL occur.
REQ-017 The block SHALL deliver exactly one broadcast per accepted entry.
- Per-source order is preserved.
- No entry is lost except by flush or rst.

Reset
REQ-018 On rst at an edge, regardless of rdy, the block SHALL set:
- All FIFO pointers and counts 0.
- last_grant=1, so ALU wins the first contention.
- cdb_valid=0; cdb_res, cdb_rob_id, cdb_jump_choice, cdb_pc and cdb_src all 0.
REQ-019 rst SHALL take priority over flush and over any push or pop in the same cycle.

Configuration
REQ-020 Macro CDB_LSB_PRIORITY_EN SHALL select the arbitration policy.
- Defined: fixed priority, LSB always wins when both FIFOs are non-empty; last_grant is not implemented.
- Undefined: round-robin per REQ-012.
- All other behaviour is identical in both builds.

Verification
REQ-021 Reset then idle: cdb_valid=0 and all cdb_* =0 for 10 cycles; alu_ready=lsb_ready=1.
REQ-022 Single ALU push at edge N (res=0x12345678, rob_id=3, jump=1, pc=0x100) -> cdb_valid=1 only in the cycle after edge N+1, with matching payload and cdb_src=0.
REQ-023 ALU and LSB push every cycle for 8 cycles from reset (default build) -> CDB alternates ALU, LSB, ALU, ...
- Each source's rob_ids appear in push order.
- All 16 entries are broadcast.
REQ-024 Five consecutive LSB pushes with ALU stalling the grant -> lsb_ready drops to 0 when count=4; the fifth valid is not accepted.
REQ-025 flush asserted with 3 entries buffered and a push on the same edge -> next cycle cdb_valid=0, both readies 1, and no stale rob_id is ever broadcast afterwards.
REQ-026 CDB_LSB_PRIORITY_EN defined, both FIFOs holding 2 entries -> both LSB entries are broadcast before any ALU entry.
